// File: rtl/mem_access_pkg.sv
// mem_access_pkg -- shared definitions for the MEM-stage access unit.
//
// Contents:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : req_size encodings (2'b11 is
//                                       reserved and handled like a word)
//   state_e                           : access FSM state encoding
//   is_misaligned()                   : natural-alignment test for a request
//   align_offset()                    : byte offset with misaligned low bits
//                                       forced to zero
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // A half must sit on an even byte, a word (or reserved size) on a
  // multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return (off != 2'b00);
    endcase
  endfunction

  // Lane offset actually used for the access. Low bits that would break
  // alignment are dropped, so a misaligned request becomes the aligned one.
  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] off);
    case (size)
      SIZE_BYTE: return off;
      SIZE_HALF: return {off[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational byte-lane steering for the access unit.
//
// Ports:
//   rdata       in  32  word read from the data memory
//   wdata       in  16  right-justified store data (only byte/half needed)
//   offset      in   2  byte offset of the access inside the word (aligned)
//   size        in   2  access size (SIZE_BYTE / SIZE_HALF / word)
//   is_unsigned in   1  zero-extend loads when 1, sign-extend when 0
//   load_data   out 32  selected lane of rdata, extended to 32 bits
//   merged      out 32  rdata with the store lane replaced by wdata
//
// Lanes are little-endian: offset 0 is bits [7:0].
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [15:0] lane;

  assign shamt = {offset, 3'b000};
  assign lane  = 16'(rdata >> shamt);

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = rdata;
    merged    = rdata;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
        merged    = (rdata & ~(32'h0000_00FF << shamt))
                  | ({24'h0, wdata[7:0]} << shamt);
      end
      SIZE_HALF: begin
        load_data = {{16{lane[15] & ~is_unsigned}}, lane};
        merged    = (rdata & ~(32'h0000_FFFF << shamt))
                  | ({16'h0, wdata} << shamt);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit in front of a single-port,
// word-wide data memory with combinational read.
//
// Loads and word stores take one cycle. Byte/half stores are
// read-modify-write: the word is read and merged in IDLE (pipeline stalled
// for that cycle), then written from a buffer in WRITE.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid            memory instruction present in MEM
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 reserved (word)
//   req_unsigned         zero-extend (1) or sign-extend (0) loads
//   req_addr, req_wdata  byte address, right-justified store data
//   stall                hold the pipeline this cycle
//   resp_valid/rdata     registered load result
//   misalign_exc         registered one-cycle misalignment pulse
//   mem_read/mem_write   memory strobes (never both)
//   mem_addr/mem_wdata   word address and write data
//   mem_rdata            combinational read data from the memory
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_SIZE_BIT = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    misalign_exc,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [RAM_SIZE_BIT-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  state_e state, next_state;

  logic       misaligned;
  logic       accept;
  logic       is_load;
  logic       is_word_store;
  logic       is_sub_store;
  logic [1:0] offset;

  logic [31:0]             load_data;
  logic [31:0]             merged;
  logic [31:0]             buf_data;
  logic [RAM_SIZE_BIT-1:0] buf_addr;

  // Address bits above the memory size are don't-care: accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:RAM_SIZE_BIT+2];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign offset = align_offset(req_size, req_addr[1:0]);

  // Request inputs only matter in IDLE; WRITE ignores them entirely.
  assign accept        = (state == IDLE) && req_valid && !misaligned && !reset;
  assign is_load       = accept && !req_write;
  assign is_sub_store  = accept && req_write &&
                         ((req_size == SIZE_BYTE) || (req_size == SIZE_HALF));
  assign is_word_store = accept && req_write && !is_sub_store;

  mem_lane_align u_lane (
    .rdata       (mem_rdata),
    .wdata       (req_wdata[15:0]),
    .offset      (offset),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .load_data   (load_data),
    .merged      (merged)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (is_sub_store) next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = req_addr[RAM_SIZE_BIT+1:2];
    mem_wdata = req_wdata;
    case (state)
      IDLE: begin
        mem_read  = is_load || is_sub_store;
        mem_write = is_word_store;
        stall     = is_sub_store;
      end
      WRITE: begin
        // A reset landing here aborts the pending merge write.
        mem_write = !reset;
        mem_addr  = buf_addr;
        mem_wdata = buf_data;
      end
      default: ;
    endcase
  end

  // Merge buffer and registered load response. The buffer is a plain
  // register pair, so it is cleared along with the rest of the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data   <= '0;
      buf_addr   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= is_load;
      if (is_load) resp_rdata <= load_data;
      if (is_sub_store) begin
        buf_data <= merged;
        buf_addr <= req_addr[RAM_SIZE_BIT+1:2];
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= (state == IDLE) && req_valid && misaligned;
  end
  assign misalign_exc = misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed, table-driven bench for mem_access_unit.
// A behavioural word memory sits on the mem_* port; expected values are
// hand-computed constants.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_exc;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_SIZE_BIT(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_exc (misalign_exc),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Both strobes at once is never legal; sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL strobe_exclusive: mem_read=1 mem_write=1 required not both");
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid    = v;
    req_write    = w;
    req_size     = s;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;       // memory contents preloaded at idx
    logic [8:0]  idx;        // expected word address
    logic [31:0] exp_rdata;  // expected load result
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0, 32'h80FF0000, 9'd4,  32'hFFFFFF80};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0, 32'h80FF0000, 9'd4,  32'h00000080};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0, 32'h80011234, 9'd4,  32'hFFFF8001};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0, 32'h80011234, 9'd4,  32'h00008001};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0, 32'h11223344, 9'd4,  32'h11223344};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h11,  32'h0, 32'h11223344, 9'd4,  32'h00000033};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h10,  32'h0, 32'h0000F00D, 9'd4,  32'hFFFFF00D};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h10,  32'h0, 32'h11223344, 9'd4,  32'h00000044};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h20,  32'hDEADBEEF, 32'h0, 9'd8,  32'h0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h814, 32'h0, 32'hCAFEF00D, 9'd5,  32'hCAFEF00D};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h30,  32'h0, 32'h01020304, 9'd12, 32'h01020304};

    for (int i = 0; i < 512; i++) mem[i] = 32'h0;

    // Reset state.
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_misalign", {31'b0, misalign_exc}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    reset = 1'b0;
    next_cycle();

    // Idle with no request: no strobes.
    #2;
    check("idle_mem_read", {31'b0, mem_read}, 32'h0);
    check("idle_mem_write", {31'b0, mem_write}, 32'h0);
    next_cycle();

    // Table: loads and word stores, all single-cycle.
    for (int i = 0; i < 11; i++) begin
      mem[vecs[i].idx] = vecs[i].word;
      drive(1'b1, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr,
            vecs[i].wdata);
      #2;
      check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
      check($sformatf("v%0d_mem_read", i), {31'b0, mem_read}, {31'b0, !vecs[i].wr});
      check($sformatf("v%0d_mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].wr});
      check($sformatf("v%0d_mem_addr", i), {23'b0, mem_addr}, {23'b0, vecs[i].idx});
      if (vecs[i].wr)
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      next_cycle();
      req_valid = 1'b0;
      check($sformatf("v%0d_resp_valid", i), {31'b0, resp_valid}, {31'b0, !vecs[i].wr});
      if (vecs[i].wr)
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].idx], vecs[i].wdata);
      else
        check($sformatf("v%0d_resp_rdata", i), resp_rdata, vecs[i].exp_rdata);
      #1;
      check($sformatf("v%0d_resp_drop", i), {31'b0, resp_valid & ~req_valid}, {31'b0, !vecs[i].wr});
      next_cycle();
      check($sformatf("v%0d_resp_idle", i), {31'b0, resp_valid}, 32'h0);
    end

    // sb 0xAA to 0x11 over 0x11223344: one stall, then merged write.
    mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
    #2;
    check("sb_stall", {31'b0, stall}, 32'h1);
    check("sb_read", {31'b0, mem_read}, 32'h1);
    check("sb_no_write", {31'b0, mem_write}, 32'h0);
    next_cycle();
    // A load presented during WRITE must be ignored.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    #2;
    check("sb_wr_stall", {31'b0, stall}, 32'h0);
    check("sb_wr_write", {31'b0, mem_write}, 32'h1);
    check("sb_wr_read", {31'b0, mem_read}, 32'h0);
    check("sb_wr_addr", {23'b0, mem_addr}, 32'h4);
    check("sb_wr_wdata", mem_wdata, 32'h1122AA44);
    next_cycle();
    req_valid = 1'b0;
    check("sb_mem_word", mem[4], 32'h1122AA44);
    check("sb_ignored_load", {31'b0, resp_valid}, 32'h0);
    next_cycle();

    // sh 0xBEEF to 0x12 over 0x11223344.
    mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
    #2;
    check("sh_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    req_valid = 1'b0;
    #2;
    check("sh_wr_wdata", mem_wdata, 32'hBEEF3344);
    next_cycle();
    check("sh_mem_word", mem[4], 32'hBEEF3344);

    // Reset during WRITE after sh 0xBEEF to 0x40: memory untouched.
    mem[16] = 32'h55667788;
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000BEEF);
    #2;
    check("rstw_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("rstw_no_write", {31'b0, mem_write}, 32'h0);
    next_cycle();
    reset = 1'b0;
    #2;
    check("rstw_idle_no_write", {31'b0, mem_write}, 32'h0);
    check("rstw_mem_word", mem[16], 32'h55667788);
    next_cycle();
    check("rstw_mem_word_later", mem[16], 32'h55667788);

    // lw from 0x22 (mem[8] holds 0xDEADBEEF from the sw vector).
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    #2;
`ifdef MISALIGN_TRAP_EN
    check("mis_no_read", {31'b0, mem_read}, 32'h0);
    check("mis_no_write", {31'b0, mem_write}, 32'h0);
    check("mis_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    req_valid = 1'b0;
    check("mis_exc", {31'b0, misalign_exc}, 32'h1);
    check("mis_resp_valid", {31'b0, resp_valid}, 32'h0);
    next_cycle();
    check("mis_exc_pulse", {31'b0, misalign_exc}, 32'h0);
`else
    check("mis_read", {31'b0, mem_read}, 32'h1);
    check("mis_addr", {23'b0, mem_addr}, 32'h8);
    next_cycle();
    req_valid = 1'b0;
    check("mis_resp_valid", {31'b0, resp_valid}, 32'h1);
    check("mis_resp_rdata", resp_rdata, 32'hDEADBEEF);
    check("mis_exc_zero", {31'b0, misalign_exc}, 32'h0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter RAM_SIZE_BIT, default 9, meaning the word-address width of the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, a memory instruction is present in the MEM stage.
REQ-005 SHALL have port req_write, input, 1, 1 = store and 0 = load.
REQ-006 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 SHALL have port req_unsigned, input, 1, zero-extend the load result when 1 and sign-extend when 0.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-010 SHALL have port stall, output, 1, hold the pipeline this cycle.
REQ-011 SHALL have port resp_valid, output, 1, registered load result valid.
REQ-012 SHALL have port resp_rdata, output, 32, registered, extended load result.
REQ-013 SHALL have port misalign_exc, output, 1, registered one-cycle pulse flagging a misaligned access.
REQ-014 SHALL have port mem_read, output, 1, to the data memory.
REQ-015 SHALL have port mem_write, output, 1, to the data memory.
REQ-016 SHALL have port mem_addr, output, RAM_SIZE_BIT, word address equal to req_addr[RAM_SIZE_BIT+1:2].
REQ-017 SHALL have port mem_wdata, output, 32, full word to write.
REQ-018 SHALL have port mem_rdata, input, 32, combinational read data from the memory, valid in the same cycle as mem_read.

Function
REQ-019 SHALL implement the FSM states IDLE and WRITE; reset enters IDLE.
REQ-020 SHALL, for a word store in IDLE, drive mem_write=1 and mem_wdata=req_wdata in the same cycle, keep stall=0, and stay in IDLE.
REQ-021 SHALL, for a byte or half store in IDLE: drive mem_read=1; merge the req_wdata lane into mem_rdata (little-endian, lane selected by req_addr[1:0]); capture the merged word and word address into a buffer; assert stall=1; and go to WRITE.
REQ-022 SHALL, in WRITE, drive mem_write=1 from the buffer, ignore all req_* inputs, keep stall=0, and return to IDLE; a sub-word store costs exactly one stall cycle.
REQ-023 SHALL, for a load in IDLE, drive mem_read=1, keep stall=0, and on the next edge register resp_valid=1 and resp_rdata = the selected lane extended per req_unsigned.
REQ-024 SHALL drive resp_valid=0 in every cycle that does not follow an accepted load, and SHALL hold resp_rdata at its last value.
REQ-025 SHALL keep mem_read=0 and mem_write=0 whenever req_valid=0 in IDLE.
REQ-026 SHALL ignore address bits above RAM_SIZE_BIT+1, so addresses wrap modulo the memory size.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle.

Reset
REQ-028 SHALL, on reset, force state=IDLE, stall=0, resp_valid=0, resp_rdata=0, misalign_exc=0, and clear the buffer.
REQ-029 SHALL, when reset is asserted in WRITE, suppress that cycle's mem_write, so the aborted store leaves memory unchanged.

Configuration
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned: no memory strobe, stall=0, resp_valid=0, and misalign_exc=1 on the next cycle.
REQ-031 SHALL, without MISALIGN_TRAP_EN, force the offending low address bits to zero, perform the aligned access, and tie misalign_exc to 0.

Structure
REQ-032 SHALL place the req_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encoding in the shared package mem_access_pkg.
REQ-033 SHALL place lane extract/extend and lane merge in a combinational sub-module mem_lane_align, instantiated once.

Verification
REQ-034 SHALL cover: memory word 0x11223344 at byte address 0x10, sb 0xAA to address 0x11 -> stall for 1 cycle, then mem_write with 0x1122AA44.
REQ-035 SHALL cover: lb from 0x13 with word 0x80FF0000 -> next cycle resp_rdata=0xFFFFFF80; lbu from 0x13 -> 0x00000080.
REQ-036 SHALL cover: lh from 0x12 with word 0x8001_1234 -> 0xFFFF8001; lhu from 0x12 -> 0x00008001.
REQ-037 SHALL cover: sw 0xDEADBEEF to 0x20 -> same-cycle mem_write with mem_addr=8, stall=0.
REQ-038 SHALL cover: with MISALIGN_TRAP_EN, lw from 0x22 -> no strobes and misalign_exc=1 for exactly one cycle; without the macro, the access is performed at 0x20.
REQ-039 SHALL cover: reset asserted in WRITE after sh 0xBEEF to 0x40 -> memory word at 0x40 unchanged and state=IDLE.
